// File: rtl/yolov4_pkg.sv
// yolov4_pkg: shared widths, descriptor layout and scheduler state encoding
package yolov4_pkg;

    localparam int N_LAYER      = 22;
    localparam int FRAME_SIZE_W = 16;
    localparam int GRP_W        = 6;
    localparam int W_CELL       = 16;
    localparam int W_CELL_PARAM = 10;
    localparam int PARAM_BITS   = 16;
    localparam int LAYER_W      = $clog2(N_LAYER);

    function automatic int desc_w(int fsw, int gw, int wc, int wcp);
        return 2 * fsw + gw + wc + wcp + 1;
    endfunction

    localparam int DESC_W = desc_w(FRAME_SIZE_W, GRP_W, W_CELL, W_CELL_PARAM);

    // Descriptor ROM word, MSB first; npix_m1 and n_grp_m1 are count-minus-one
    typedef struct packed {
        logic                    is_last;
        logic [FRAME_SIZE_W-1:0] npix_m1;
        logic [FRAME_SIZE_W-1:0] base_addr;
        logic [GRP_W-1:0]        n_grp_m1;
        logic [W_CELL-1:0]       w_base;
        logic [W_CELL_PARAM-1:0] p_base;
    } desc_t;

    typedef enum logic [2:0] {
        IDLE, DREQ, DLAT, PREQ, PLAT, RUN, NEXT, DONE
    } state_e;

endpackage

// File: rtl/yolov4_pix_cnt.sv
// yolov4_pix_cnt: pixel, group and fmap write-address counters with end-of-group/layer flags
module yolov4_pix_cnt
    import yolov4_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    load_i,
    input  logic [FRAME_SIZE_W-1:0] base_i,
    input  logic [FRAME_SIZE_W-1:0] npix_m1_i,
    input  logic [GRP_W-1:0]        n_grp_m1_i,
    input  logic                    grp_inc_i,
    input  logic                    cnt_i,
    output logic [FRAME_SIZE_W-1:0] pixel_count_o,
    output logic [GRP_W-1:0]        grp_o,
    output logic                    pix_last_o,
    output logic                    grp_last_o,
    output logic                    err_ovf_o
);

    logic [FRAME_SIZE_W-1:0] pc_q, pc_d, pix_q, pix_d;
    logic [GRP_W-1:0]        grp_q, grp_d;
    logic                    sat_q, sat_d, err_q, err_d;
    logic                    at_max;

    assign at_max        = &pc_q;
    assign pixel_count_o = pc_q;
    assign grp_o         = grp_q;
    assign pix_last_o    = pix_q == npix_m1_i;
    assign grp_last_o    = grp_q == n_grp_m1_i;
    assign err_ovf_o     = err_q;

    // The all-ones address is a legal write slot; sat marks it used, so only a further word overflows
    always_comb begin
        pc_d  = load_i ? base_i : (cnt_i && !at_max) ? pc_q + 1'b1 : pc_q;
        pix_d = (load_i || grp_inc_i) ? '0 : cnt_i ? pix_q + 1'b1 : pix_q;
        grp_d = load_i ? '0 : grp_inc_i ? grp_q + 1'b1 : grp_q;
        sat_d = load_i ? 1'b0 : (cnt_i && at_max) ? 1'b1 : sat_q;
        err_d = err_q | (cnt_i && at_max && sat_q);
    end

    // Counter state; err is sticky until reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q  <= '0;
            pix_q <= '0;
            grp_q <= '0;
            sat_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            pix_q <= pix_d;
            grp_q <= grp_d;
            sat_q <= sat_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/yolov4_layer_sched.sv
// yolov4_layer_sched: walks the layer-descriptor ROM and sequences param fetch and conv_kern per output group
module yolov4_layer_sched
    import yolov4_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    output logic [LAYER_W-1:0]      desc_addr,
    output logic                    desc_en,
    input  logic [DESC_W-1:0]       desc_data,
    output logic                    param_buf_en,
    output logic [W_CELL_PARAM-1:0] param_buf_addr,
    input  logic [PARAM_BITS-1:0]   param_bias_i,
    input  logic [PARAM_BITS-1:0]   param_scale_i,
    output logic [PARAM_BITS-1:0]   bias_o,
    output logic [PARAM_BITS-1:0]   scale_o,
    output logic [W_CELL-1:0]       weight_base_o,
    output logic                    kern_start,
    input  logic                    vld_i,
    output logic [FRAME_SIZE_W-1:0] pixel_count,
    output logic                    out_buff_sel,
    output logic                    is_last_layer,
    output logic                    busy,
    output logic                    done,
    output logic                    err_ovf
);

    state_e                  state_q, state_d;
    logic [LAYER_W-1:0]      layer_q, layer_d;
    logic                    sel_q, sel_d, ks_q, ks_d;
    logic                    last_q;
    logic [FRAME_SIZE_W-1:0] npix_q;
    logic [GRP_W-1:0]        ngrp_q, grp;
    logic [W_CELL-1:0]       wbase_q;
    logic [W_CELL_PARAM-1:0] pbase_q;
    logic [PARAM_BITS-1:0]   bias_q, scale_q;
    logic                    load, grp_inc, cnt, pix_last, grp_last;
    desc_t                   desc;

    assign desc           = desc_t'(desc_data);
    assign load           = state_q == DLAT;
    assign cnt            = state_q == RUN && vld_i;
    assign grp_inc        = state_q == NEXT && !grp_last;
    assign desc_addr      = layer_q;
    assign desc_en        = state_q == DREQ;
    assign param_buf_en   = state_q == PREQ;
    assign param_buf_addr = pbase_q + {{(W_CELL_PARAM - GRP_W){1'b0}}, grp};
    assign bias_o         = bias_q;
    assign scale_o        = scale_q;
    assign weight_base_o  = wbase_q;
    assign kern_start     = ks_q;
    assign out_buff_sel   = sel_q;
    assign is_last_layer  = last_q;
    assign busy           = state_q != IDLE;
    assign done           = state_q == DONE;

    yolov4_pix_cnt u_pix_cnt (
        .clk          (clk),
        .rstn         (rstn),
        .load_i       (load),
        .base_i       (desc.base_addr),
        .npix_m1_i    (npix_q),
        .n_grp_m1_i   (ngrp_q),
        .grp_inc_i    (grp_inc),
        .cnt_i        (cnt),
        .pixel_count_o(pixel_count),
        .grp_o        (grp),
        .pix_last_o   (pix_last),
        .grp_last_o   (grp_last),
        .err_ovf_o    (err_ovf)
    );

    // Next state, layer index, ping-pong toggle and the kern_start pulse issued on leaving PLAT
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        sel_d   = sel_q;
        ks_d    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = DREQ;
                layer_d = '0;
            end
            DREQ: state_d = DLAT;
            DLAT: state_d = PREQ;
            PREQ: state_d = PLAT;
            PLAT: begin
                state_d = RUN;
                ks_d    = 1'b1;
            end
            RUN:  state_d = (vld_i && pix_last) ? NEXT : RUN;
            NEXT: if (!grp_last) begin
                state_d = PREQ;
            end else if (last_q || layer_q == LAYER_W'(N_LAYER - 1)) begin
                state_d = DONE;
            end else begin
                state_d = DREQ;
                layer_d = layer_q + 1'b1;
                sel_d   = ~sel_q;
            end
            DONE: begin
                state_d = IDLE;
                sel_d   = ~sel_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and sequencing registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            layer_q <= '0;
            sel_q   <= 1'b0;
            ks_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            sel_q   <= sel_d;
            ks_q    <= ks_d;
        end
    end

    // Descriptor fields captured when ROM data is valid, params when buffer data is valid
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q  <= 1'b0;
            npix_q  <= '0;
            ngrp_q  <= '0;
            wbase_q <= '0;
            pbase_q <= '0;
            bias_q  <= '0;
            scale_q <= '0;
        end else begin
            if (state_q == DLAT) begin
                last_q  <= desc.is_last;
                npix_q  <= desc.npix_m1;
                ngrp_q  <= desc.n_grp_m1;
                wbase_q <= desc.w_base;
                pbase_q <= desc.p_base;
            end
            if (state_q == PLAT) begin
                bias_q  <= param_bias_i;
                scale_q <= param_scale_i;
            end
        end
    end

endmodule

// File: tb/tb_yolov4_layer_sched.sv
// tb_yolov4_layer_sched: directed checks of the layer scheduler against hand-computed values
module tb_yolov4_layer_sched;
    import yolov4_pkg::*;

    logic                    clk = 1'b0;
    logic                    rstn = 1'b0;
    logic                    start = 1'b0;
    logic                    vld_i = 1'b0;
    logic [LAYER_W-1:0]      desc_addr;
    logic                    desc_en;
    logic [DESC_W-1:0]       desc_data = '0;
    logic                    param_buf_en;
    logic [W_CELL_PARAM-1:0] param_buf_addr;
    logic [PARAM_BITS-1:0]   p_bias = '0, p_scale = '0;
    logic [PARAM_BITS-1:0]   bias_o, scale_o;
    logic [W_CELL-1:0]       weight_base_o;
    logic                    kern_start;
    logic [FRAME_SIZE_W-1:0] pixel_count;
    logic                    out_buff_sel, is_last_layer, busy, done, err_ovf;

    desc_t rom [N_LAYER];
    int    checks = 0, errors = 0, ks_cnt = 0, done_cnt = 0, lat = 0;
    logic [W_CELL_PARAM-1:0] pb_q [$];
    logic [15:0] ovf_pc  [4] = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    logic        ovf_err [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    yolov4_layer_sched dut (
        .clk(clk), .rstn(rstn), .start(start),
        .desc_addr(desc_addr), .desc_en(desc_en), .desc_data(desc_data),
        .param_buf_en(param_buf_en), .param_buf_addr(param_buf_addr),
        .param_bias_i(p_bias), .param_scale_i(p_scale),
        .bias_o(bias_o), .scale_o(scale_o), .weight_base_o(weight_base_o),
        .kern_start(kern_start), .vld_i(vld_i), .pixel_count(pixel_count),
        .out_buff_sel(out_buff_sel), .is_last_layer(is_last_layer),
        .busy(busy), .done(done), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    // Descriptor ROM and param buffers, 1-cycle read latency
    always @(posedge clk) begin
        if (desc_en) desc_data <= rom[desc_addr];
        if (param_buf_en) begin
            p_bias  <= 16'hB000 | {6'b0, param_buf_addr};
            p_scale <= 16'h5000 | {6'b0, param_buf_addr};
        end
    end

    // Event monitor
    always @(negedge clk) begin
        if (kern_start) ks_cnt++;
        if (done) done_cnt++;
        if (param_buf_en) pb_q.push_back(param_buf_addr);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic desc_t mk(logic last, logic [15:0] npix, logic [15:0] base,
                                 logic [5:0] ngrp, logic [15:0] wb, logic [9:0] pb);
        return {last, npix, base, ngrp, wb, pb};
    endfunction

    task automatic do_reset();
        rstn  = 1'b0;
        start = 1'b0;
        vld_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        ks_cnt   = 0;
        done_cnt = 0;
        pb_q.delete();
    endtask

    task automatic start_run(output int n);
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!kern_start && n < 40);
        check("start_ks", kern_start, 1);
    endtask

    task automatic wait_ks();
        int n = 0;
        @(negedge clk);
        while (!kern_start && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ks_seen", kern_start, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic drive_vld(input int n, input logic [15:0] first);
        for (int i = 0; i < n; i++) begin
            vld_i = 1'b1;
            check("pc", pixel_count, 32'(first + 16'(i)));
            @(negedge clk);
        end
        vld_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N_LAYER; i++) rom[i] = '0;
        // Reset state
        do_reset();
        rstn = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", {desc_en, param_buf_en, kern_start}, 0);
        check("rst_pc", pixel_count, 0);
        check("rst_sel", out_buff_sel, 0);
        check("rst_err", err_ovf, 0);
        check("rst_addr", desc_addr, 0);
        check("rst_bias", bias_o, 0);
        // Single layer, 4 pixels, one group
        rom[0] = mk(1, 16'd3, 16'h0000, 6'd0, 16'h1234, 10'h000);
        do_reset();
        start_run(lat);
        check("t1_lat", lat, 5);
        check("t1_bias", bias_o, 16'hB000);
        check("t1_scale", scale_o, 16'h5000);
        check("t1_wbase", weight_base_o, 16'h1234);
        check("t1_last", is_last_layer, 1);
        drive_vld(4, 16'h0000);
        check("t1_done_early", done, 0);
        wait_done();
        check("t1_sel_in_done", out_buff_sel, 0);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_sel", out_buff_sel, 1);
        check("t1_busy", busy, 0);
        check("t1_pc", pixel_count, 4);
        check("t1_done_cnt", done_cnt, 1);
        // One layer, three groups of two pixels, p_base 0x10
        rom[0] = mk(1, 16'd1, 16'h0000, 6'd2, 16'h0040, 10'h010);
        do_reset();
        start_run(lat);
        for (int g = 0; g < 3; g++) begin
            if (g > 0) wait_ks();
            check("t2_bias", bias_o, 32'(16'hB010 + 16'(g)));
            drive_vld(2, 16'(2 * g));
        end
        wait_done();
        check("t2_ks_cnt", ks_cnt, 3);
        check("t2_pb_n", pb_q.size(), 3);
        for (int g = 0; g < 3 && g < pb_q.size(); g++) check("t2_pb_addr", pb_q[g], 32'h10 + 32'(g));
        check("t2_pc", pixel_count, 6);
        // Three layers, last flag on layer 2
        rom[0] = mk(0, 16'd1, 16'h0000, 6'd0, 16'h0100, 10'h000);
        rom[1] = mk(0, 16'd1, 16'h0100, 6'd0, 16'h0200, 10'h020);
        rom[2] = mk(1, 16'd1, 16'h0200, 6'd0, 16'h0300, 10'h040);
        do_reset();
        start_run(lat);
        for (int l = 0; l < 3; l++) begin
            if (l > 0) wait_ks();
            check("t3_addr", desc_addr, 32'(l));
            check("t3_sel", out_buff_sel, 32'(l % 2));
            check("t3_last", is_last_layer, 32'(l == 2));
            check("t3_wbase", weight_base_o, 32'h100 * 32'(l + 1));
            drive_vld(2, 16'(16'h100 * l));
        end
        wait_done();
        @(negedge clk);
        check("t3_sel_after", out_buff_sel, 1);
        check("t3_done_cnt", done_cnt, 1);
        // vld_i in IDLE is ignored
        vld_i = 1'b1;
        repeat (3) @(negedge clk);
        vld_i = 1'b0;
        check("t4_idle_pc", pixel_count, 16'h0202);
        check("t4_idle_err", err_ovf, 0);
        // vld_i held high through DREQ..PLAT and NEXT/PREQ: only RUN cycles count
        rom[0] = mk(1, 16'd0, 16'h0040, 6'd1, 16'h0000, 10'h000);
        do_reset();
        vld_i = 1'b1;
        start_run(lat);
        check("t4_pc0", pixel_count, 16'h0040);
        @(negedge clk);
        wait_ks();
        check("t4_pc1", pixel_count, 16'h0041);
        @(negedge clk);
        vld_i = 1'b0;
        wait_done();
        check("t4_pc_end", pixel_count, 16'h0042);
        check("t4_err", err_ovf, 0);
        // Write address saturation and sticky overflow
        rom[0] = mk(1, 16'd3, 16'hFFFE, 6'd0, 16'h0000, 10'h000);
        do_reset();
        start_run(lat);
        for (int i = 0; i < 4; i++) begin
            vld_i = 1'b1;
            check("t5_pc", pixel_count, 32'(ovf_pc[i]));
            @(negedge clk);
            check("t5_err", err_ovf, 32'(ovf_err[i]));
        end
        vld_i = 1'b0;
        wait_done();
        @(negedge clk);
        check("t5_err_sticky", err_ovf, 1);
        // Reset during layer 1, then replay from layer 0
        rom[0] = mk(0, 16'd1, 16'h0000, 6'd0, 16'h0100, 10'h000);
        rom[1] = mk(0, 16'd1, 16'h0100, 6'd0, 16'h0200, 10'h020);
        rom[2] = mk(1, 16'd1, 16'h0200, 6'd0, 16'h0300, 10'h040);
        do_reset();
        start_run(lat);
        drive_vld(2, 16'h0000);
        wait_ks();
        check("t6_addr1", desc_addr, 1);
        check("t6_sel1", out_buff_sel, 1);
        drive_vld(1, 16'h0100);
        rstn = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_sel", out_buff_sel, 0);
        check("t6_pc", pixel_count, 0);
        check("t6_addr", desc_addr, 0);
        @(negedge clk);
        check("t6_no_done", done_cnt, 0);
        rstn = 1'b1;
        start_run(lat);
        check("t6_replay_addr", desc_addr, 0);
        check("t6_replay_wbase", weight_base_o, 16'h0100);
        check("t6_replay_pc", pixel_count, 0);
        check("t6_replay_sel", out_buff_sel, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
